// File: rtl/bp_meta_update_sched_if.sv
// Writeback update channel and meta-table port of the meta update scheduler.
// The scheduler uses the slave view; the writeback stage and table side use master.
interface bp_meta_update_sched_if #(
   parameter int IDX_BITS = 8
);
   logic                upd_valid;
   logic [15:0]         upd_pc;
   logic                upd_lc_correct;
   logic                upd_gl_correct;
   logic                upd_ready;
   logic [IDX_BITS-1:0] tbl_idx;
   logic [1:0]          tbl_rdata;
   logic                tbl_we;
   logic [1:0]          tbl_wdata;

   modport master (
      output upd_valid, upd_pc, upd_lc_correct, upd_gl_correct,
      input  upd_ready,
      input  tbl_idx, tbl_we, tbl_wdata,
      output tbl_rdata
   );

   modport slave (
      input  upd_valid, upd_pc, upd_lc_correct, upd_gl_correct,
      output upd_ready,
      output tbl_idx, tbl_we, tbl_wdata,
      input  tbl_rdata
   );
endinterface

// File: rtl/bp_meta_update_sched.sv
// Meta (choice) table update scheduler: queues resolved branches, applies them as
// serialized read-modify-writes, and sweeps the table to INIT_STATE after reset/flush.
module bp_meta_update_sched #(
   parameter int         IDX_BITS   = 8,
   parameter int         QDEPTH     = 4,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    flush,
   bp_meta_update_sched_if.slave   bus,
   output logic                    pred_enable,
   output logic [15:0]             upd_count
);
   localparam int PTR_BITS = $clog2(QDEPTH);
   localparam int ENT_BITS = IDX_BITS + 2;
   localparam logic [PTR_BITS:0] FULL_CNT = QDEPTH[PTR_BITS:0];

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_RMW  = 2'd2
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   logic [IDX_BITS-1:0]   sweep_r;
   logic [IDX_BITS-1:0]   hold_idx_r;
   logic                  hold_inc_r;
   logic [ENT_BITS-1:0]   fifo_mem_r [QDEPTH];
   logic [PTR_BITS-1:0]   wr_ptr_r;
   logic [PTR_BITS-1:0]   rd_ptr_r;
   logic [PTR_BITS:0]     count_r;
   logic [PTR_BITS:0]     count_nxt_s;
   logic                  upd_ready_r;
   logic                  pred_enable_r;
   logic [15:0]           upd_count_r;

   logic                  push_s;
   logic                  pop_s;
   logic                  fifo_empty_s;
   logic                  rmw_write_s;
   logic [ENT_BITS-1:0]   entry_s;
   logic [ENT_BITS-1:0]   head_s;
   logic [IDX_BITS-1:0]   head_idx_s;
   logic                  head_lc_s;
   logic                  head_gl_s;
   logic                  unused_pc_bits_s;

   // Saturating 2-bit counter step toward local (inc) or global (dec).
   function automatic logic [1:0] meta_next(input logic [1:0] cur, input logic inc);
      logic [1:0] res;
      if (inc) begin
         if (cur == 2'b11) res = 2'b11;
         else              res = cur + 2'b01;
      end else begin
         if (cur == 2'b00) res = 2'b00;
         else              res = cur - 2'b01;
      end
      return res;
   endfunction

   assign entry_s          = {bus.upd_pc[IDX_BITS:1], bus.upd_lc_correct, bus.upd_gl_correct};
   assign unused_pc_bits_s = ^{bus.upd_pc[15:IDX_BITS+1], bus.upd_pc[0]};
   assign head_s           = fifo_mem_r[rd_ptr_r];
   assign head_idx_s       = head_s[ENT_BITS-1:2];
   assign head_lc_s        = head_s[1];
   assign head_gl_s        = head_s[0];
   assign fifo_empty_s     = (count_r == {(PTR_BITS+1){1'b0}});
   // upd_ready_r is already low in INIT and when full, so it fully qualifies the push.
   assign push_s           = bus.upd_valid && upd_ready_r && !flush;
   assign rmw_write_s      = (state_r == ST_RMW) && !flush;

   // Next-state logic and FIFO pop decision.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      if (flush) begin
         state_nxt_s = ST_INIT;
      end else begin
         case (state_r)
            ST_INIT: begin
               if (sweep_r == {IDX_BITS{1'b1}}) state_nxt_s = ST_IDLE;
               else                             state_nxt_s = ST_INIT;
            end
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  pop_s = 1'b1;
                  if (head_lc_s != head_gl_s) state_nxt_s = ST_RMW;
                  else                        state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RMW:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_INIT;
         endcase
      end
   end

   // FIFO occupancy after this cycle's push/pop or flush.
   always_comb begin
      if (flush) count_nxt_s = {(PTR_BITS+1){1'b0}};
      else       count_nxt_s = count_r + (PTR_BITS+1)'(push_s) - (PTR_BITS+1)'(pop_s);
   end

   // Table port drive; the write enable is forced low while reset is asserted.
   always_comb begin
      bus.tbl_we    = 1'b0;
      bus.tbl_idx   = sweep_r;
      bus.tbl_wdata = 2'b00;
      case (state_r)
         ST_INIT: begin
            bus.tbl_we    = reset_n;
            bus.tbl_idx   = sweep_r;
            bus.tbl_wdata = INIT_STATE;
         end
         ST_IDLE: begin
            bus.tbl_we    = 1'b0;
            bus.tbl_idx   = head_idx_s;
            bus.tbl_wdata = 2'b00;
         end
         ST_RMW: begin
            bus.tbl_we    = reset_n && rmw_write_s;
            bus.tbl_idx   = hold_idx_r;
            bus.tbl_wdata = meta_next(bus.tbl_rdata, hold_inc_r);
         end
         default: begin
            bus.tbl_we    = 1'b0;
            bus.tbl_idx   = sweep_r;
            bus.tbl_wdata = 2'b00;
         end
      endcase
   end

   // FSM state and init sweep counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_INIT;
         sweep_r <= {IDX_BITS{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (flush)                    sweep_r <= {IDX_BITS{1'b0}};
         else if (state_r == ST_INIT)  sweep_r <= sweep_r + IDX_BITS'(1);
         else                          sweep_r <= sweep_r;
      end
   end

   // Index and direction of the update whose write happens in RMW.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_idx_r <= {IDX_BITS{1'b0}};
         hold_inc_r <= 1'b0;
      end else if (pop_s && (head_lc_s != head_gl_s)) begin
         hold_idx_r <= head_idx_s;
         hold_inc_r <= head_lc_s;
      end
   end

   // Update FIFO storage and pointers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r <= {PTR_BITS{1'b0}};
         rd_ptr_r <= {PTR_BITS{1'b0}};
         count_r  <= {(PTR_BITS+1){1'b0}};
         for (int i = 0; i < QDEPTH; i++) fifo_mem_r[i] <= {ENT_BITS{1'b0}};
      end else begin
         if (flush) begin
            wr_ptr_r <= {PTR_BITS{1'b0}};
            rd_ptr_r <= {PTR_BITS{1'b0}};
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_BITS'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_BITS'(1);
         end
         count_r <= count_nxt_s;
         if (push_s) fifo_mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // Registered status outputs and saturating update-write counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         upd_ready_r   <= 1'b0;
         pred_enable_r <= 1'b0;
         upd_count_r   <= 16'h0000;
      end else begin
         upd_ready_r   <= (state_nxt_s != ST_INIT) && (count_nxt_s != FULL_CNT);
         pred_enable_r <= (state_nxt_s != ST_INIT);
         if (rmw_write_s && (upd_count_r != 16'hFFFF)) upd_count_r <= upd_count_r + 16'h0001;
      end
   end

   assign bus.upd_ready = upd_ready_r;
   assign pred_enable   = pred_enable_r;
   assign upd_count     = upd_count_r;

endmodule

// File: tb/tb_bp_meta_update_sched.sv
// Self-checking bench for bp_meta_update_sched: directed phases with randomized
// updates, checked against a table-level model of the meta counters.
module tb_bp_meta_update_sched;
   localparam int IDX_BITS = 8;
   localparam int QDEPTH   = 4;
   localparam int N        = 256;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        flush = 1'b0;
   logic        pred_enable;
   logic [15:0] upd_count;

   bp_meta_update_sched_if #(.IDX_BITS(IDX_BITS)) bus ();

   bp_meta_update_sched #(
      .IDX_BITS(IDX_BITS), .QDEPTH(QDEPTH), .INIT_STATE(2'b01)
   ) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus),
      .pred_enable(pred_enable), .upd_count(upd_count)
   );

   always #5 clk = ~clk;

   // Meta table memory seen by the DUT, plus a log of every write.
   logic [1:0] mem [N];
   logic [1:0] rdata_r;
   int         cyc = 0;
   int         wlog_idx[$];
   int         wlog_val[$];
   int         wlog_cyc[$];
   assign bus.tbl_rdata = rdata_r;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset_n) begin
         if (bus.tbl_we) begin
            mem[bus.tbl_idx] <= bus.tbl_wdata;
            wlog_idx.push_back(int'(bus.tbl_idx));
            wlog_val.push_back(int'(bus.tbl_wdata));
            wlog_cyc.push_back(cyc);
         end else begin
            rdata_r <= mem[bus.tbl_idx];
         end
      end
   end

   // Reference model: counter values and the ordered list of expected writes.
   int ref_tbl[N];
   int exp_idx[$];
   int exp_val[$];
   int exp_cnt;
   int checks;
   int failures;
   bit saw_stall;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic void model_apply(input int pc, input bit lc, input bit gl);
      int idx;
      int v;
      idx = (pc / 2) % N;
      if (lc != gl) begin
         v = ref_tbl[idx] + (lc ? 1 : -1);
         if (v > 3) v = 3;
         if (v < 0) v = 0;
         ref_tbl[idx] = v;
         exp_idx.push_back(idx);
         exp_val.push_back(v);
         exp_cnt++;
      end
   endfunction

   task automatic model_reinit();
      for (int i = 0; i < N; i++) ref_tbl[i] = 1;
      exp_idx.delete(); exp_val.delete();
      wlog_idx.delete(); wlog_val.delete(); wlog_cyc.delete();
   endtask

   // Offer one update starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input int pc, input bit lc, input bit gl);
      int guard;
      bit done;
      guard = 0;
      done  = 1'b0;
      bus.upd_valid      = 1'b1;
      bus.upd_pc         = 16'(pc);
      bus.upd_lc_correct = lc;
      bus.upd_gl_correct = gl;
      while (!done && guard < 64) begin
         if (bus.upd_ready === 1'b1) begin
            @(posedge clk);
            model_apply(pc, lc, gl);
            done = 1'b1;
            @(negedge clk);
         end else begin
            saw_stall = 1'b1;
            @(negedge clk);
            guard++;
         end
      end
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   // Called in the first INIT cycle; checks all sweep cycles and the first IDLE cycle.
   task automatic check_sweep(input string tag);
      int bad;
      bad = 0;
      for (int c = 0; c < N; c++) begin
         if (bus.tbl_we !== 1'b1 || bus.tbl_idx !== 8'(c) || bus.tbl_wdata !== 2'b01 ||
             pred_enable !== 1'b0 || bus.upd_ready !== 1'b0) bad++;
         if (c < N - 1) @(negedge clk);
      end
      chk({tag, "_cycles"}, bad, 0);
      @(negedge clk);
      chk({tag, "_pred_on"}, pred_enable, 1);
      chk({tag, "_ready_on"}, bus.upd_ready, 1);
      chk({tag, "_we_off"}, bus.tbl_we, 0);
      model_reinit();
   endtask

   task automatic drain(input string tag);
      int bad;
      int n;
      repeat (2 * QDEPTH + 8) @(negedge clk);
      chk({tag, "_nwrites"}, wlog_idx.size(), exp_idx.size());
      n = (wlog_idx.size() < exp_idx.size()) ? wlog_idx.size() : exp_idx.size();
      bad = 0;
      for (int i = 0; i < n; i++)
         if (wlog_idx[i] != exp_idx[i] || wlog_val[i] != exp_val[i]) bad++;
      chk({tag, "_order"}, bad, 0);
      bad = 0;
      for (int i = 0; i < N; i++) if (int'(mem[i]) != ref_tbl[i]) bad++;
      chk({tag, "_table"}, bad, 0);
      chk({tag, "_count"}, upd_count, exp_cnt);
      exp_idx.delete(); exp_val.delete();
      wlog_idx.delete(); wlog_val.delete(); wlog_cyc.delete();
   endtask

   initial begin
      int bad;
      int guard;
      int cnt_before;
      bus.upd_valid = 1'b0; bus.upd_pc = 16'h0000;
      bus.upd_lc_correct = 1'b0; bus.upd_gl_correct = 1'b0;
      checks = 0; failures = 0; exp_cnt = 0; saw_stall = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_we", bus.tbl_we, 0);
      chk("rst_pred", pred_enable, 0);
      chk("rst_ready", bus.upd_ready, 0);
      chk("rst_count", upd_count, 0);
      reset_n = 1'b1;
      #1;
      check_sweep("sweep0");

      // Latency and increment saturation on idx 8.
      send(32'h0010, 1'b1, 1'b0);
      bus.upd_valid = 1'b0;
      chk("lat_read_we", bus.tbl_we, 0);
      chk("lat_read_idx", bus.tbl_idx, 8);
      @(negedge clk);
      chk("lat_write_we", bus.tbl_we, 1);
      chk("lat_write_idx", bus.tbl_idx, 8);
      chk("lat_write_data", bus.tbl_wdata, 2);
      @(negedge clk);
      chk("lat_count", upd_count, 1);
      send(32'h0010, 1'b1, 1'b0);
      send(32'h0010, 1'b1, 1'b0);
      bus.upd_valid = 1'b0;
      drain("incr");
      chk("incr_count_abs", upd_count, 3);
      chk("incr_idx8", mem[8], 3);

      // Decrement then a no-op on idx 255.
      send(32'h01FE, 1'b0, 1'b1);
      send(32'h01FE, 1'b1, 1'b1);
      bus.upd_valid = 1'b0;
      drain("decnoop");
      chk("dec_idx255", mem[255], 0);
      chk("dec_count_abs", upd_count, 4);

      // Back-to-back effective updates until the FIFO backs up.
      saw_stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bit lc;
         lc = 1'($urandom_range(0, 1));
         send(int'($urandom_range(0, 65535)), lc, !lc);
      end
      bus.upd_valid = 1'b0;
      repeat (12) @(negedge clk);
      chk("bp_stall_seen", saw_stall, 1);
      bad = 0;
      for (int i = 1; i < wlog_cyc.size(); i++) if (wlog_cyc[i] - wlog_cyc[i-1] != 2) bad++;
      chk("bp_cadence", bad, 0);
      drain("bp");

      // Randomized mix with heavy index reuse, no-ops and idle gaps.
      for (int i = 0; i < 40; i++) begin
         int pc;
         pc = int'(($urandom_range(0, 127) << 9) | ($urandom_range(0, 3) << 1) | $urandom_range(0, 1));
         send(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            bus.upd_valid = 1'b0;
            @(negedge clk);
         end
      end
      bus.upd_valid = 1'b0;
      drain("rand");

      // Flush during an RMW with two entries still queued.
      cnt_before = int'(upd_count);
      for (int i = 0; i < 4; i++) send(32'h0020 + 2 * i, 1'b1, 1'b0);
      bus.upd_valid = 1'b0;
      guard = 0;
      while (wlog_idx.size() < 1 && guard < 20) begin @(negedge clk); guard++; end
      guard = 0;
      while (bus.tbl_we !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      chk("flush_wait_rmw", bus.tbl_we, 1);
      flush = 1'b1;
      bus.upd_valid = 1'b1; bus.upd_pc = 16'h0040;
      bus.upd_lc_correct = 1'b1; bus.upd_gl_correct = 1'b0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.upd_valid = 1'b0;
      chk("flush_nowrite", wlog_idx.size(), 1);
      @(negedge clk);
      check_sweep("sweep_flush");
      chk("flush_count", upd_count, cnt_before + 1);
      repeat (10) @(negedge clk);
      chk("flush_dropped", wlog_idx.size(), 0);
      exp_cnt = cnt_before + 1;

      for (int i = 0; i < 10; i++) begin
         int pc;
         pc = int'($urandom_range(0, 65535));
         send(pc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      bus.upd_valid = 1'b0;
      drain("post_flush");

      // Async reset in the middle of a sweep.
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      guard = 0;
      while (!(bus.tbl_we === 1'b1 && bus.tbl_idx === 8'd100) && guard < 300) begin
         @(negedge clk); guard++;
      end
      chk("areset_reach_100", bus.tbl_idx, 100);
      #2;
      reset_n = 1'b0;
      #1;
      chk("areset_we", bus.tbl_we, 0);
      chk("areset_pred", pred_enable, 0);
      chk("areset_count", upd_count, 0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      exp_cnt = 0;
      check_sweep("sweep_areset");
      send(32'h0010, 1'b0, 1'b1);
      send(32'h0012, 1'b1, 1'b0);
      bus.upd_valid = 1'b0;
      drain("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
